// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and trigger-mode encodings for the interrupt front-end
package irq_pkg;
  localparam int N_CH  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    TRIG_LEVEL = 1'b0,
    TRIG_EDGE  = 1'b1
  } trig_mode_e;

  localparam logic [N_CH-1:0] EDGE_SEL_DEFAULT = 8'hFF;
endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - one channel: synchroniser chain, history flop and capture event
import irq_pkg::*;

module irq_sync_edge #(
  parameter int         SYNC_STAGES = 2,
  parameter trig_mode_e MODE        = TRIG_EDGE
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic cap
);
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES:0]   fill;
  logic                   hist;
  logic                   s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      fill <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], line};
      fill <= {fill[SYNC_STAGES-1:0], 1'b1};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // fill marks when hist holds a real sample, so a line already high at reset release is not an edge
  assign cap = (MODE == TRIG_EDGE) ? (s & ~hist & fill[SYNC_STAGES]) : s;
endmodule

// File: rtl/irq_request_capture.sv
// rtl/irq_request_capture.sv - captures 8 async interrupt lines into pending, masks them for the encoder
import irq_pkg::*;

module irq_request_capture #(
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_CH-1:0] EDGE_SEL    = EDGE_SEL_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   irq_in,
  input  logic [N_CH-1:0]   mask,
  input  logic              ack,
  input  logic [IDX_W-1:0]  ack_idx,
  input  logic [N_CH-1:0]   ovr_clr,
  output logic [N_CH-1:0]   req_out,
  output logic              irq,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   overrun,
  output logic              ack_err
);
  logic [N_CH-1:0] cap;
  logic [N_CH-1:0] clr;
  logic [N_CH-1:0] cap_eff;
  logic [N_CH-1:0] ovr_set;
  logic [N_CH-1:0] pending_n;
  logic [N_CH-1:0] overrun_n;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .MODE       (trig_mode_e'(EDGE_SEL[i]))
    ) u_sync (
      .clk (clk),
      .rst (rst),
      .line(irq_in[i]),
      .cap (cap[i])
    );
  end

  always_comb begin
    clr = '0;
    if (ack) clr[ack_idx] = pending[ack_idx];
    // a level line still high must show one idle cycle after its ack before re-pending
    cap_eff   = cap & ~(clr & ~EDGE_SEL);
    ovr_set   = cap & pending & ~clr & EDGE_SEL;
    pending_n = cap_eff | (pending & ~clr);
    overrun_n = ovr_set | (overrun & ~ovr_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
      ack_err <= 1'b0;
    end else begin
      pending <= pending_n;
      overrun <= overrun_n;
      ack_err <= ack & ~pending[ack_idx];
    end
  end

  assign req_out = pending & ~mask;
  assign irq     = |req_out;
endmodule

// File: tb/tb_irq_request_capture.sv
// tb/tb_irq_request_capture.sv - randomized and directed self-checking bench for irq_request_capture
import irq_pkg::*;

module tb_irq_request_capture;
  localparam int         SS = 2;
  localparam logic [7:0] ES = 8'hFE;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in, mask, ovr_clr;
  logic       ack;
  logic [2:0] ack_idx;
  logic [7:0] req_out, pending, overrun;
  logic       irq, ack_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pend = '0;
  logic [7:0] m_ovr  = '0;
  logic       m_err  = 1'b0;
  logic [7:0] smp[$];

  irq_request_capture #(.SYNC_STAGES(SS), .EDGE_SEL(ES)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask), .ack(ack),
    .ack_idx(ack_idx), .ovr_clr(ovr_clr), .req_out(req_out), .irq(irq),
    .pending(pending), .overrun(overrun), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("req_out", {24'd0, req_out}, {24'd0, m_pend & ~mask});
    check("irq", {31'd0, irq}, {31'd0, |(m_pend & ~mask)});
    check("pending", {24'd0, pending}, {24'd0, m_pend});
    check("overrun", {24'd0, overrun}, {24'd0, m_ovr});
    check("ack_err", {31'd0, ack_err}, {31'd0, m_err});
  endtask

  // samples taken at each edge since reset; s is the sample SS edges back, h the one before it
  task automatic model_edge();
    logic [7:0] s, h, clr, nxt, set;
    bit         h_ok;
    smp.push_front(irq_in);
    if (smp.size() > SS + 2) void'(smp.pop_back());
    s    = (smp.size() > SS) ? smp[SS] : 8'h00;
    h_ok = smp.size() > SS + 1;
    h    = h_ok ? smp[SS+1] : 8'h00;
    clr  = 8'h00;
    if (ack && m_pend[ack_idx]) clr[ack_idx] = 1'b1;
    set = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (ES[i]) begin
        nxt[i] = (h_ok && s[i] && !h[i]) || (m_pend[i] && !clr[i]);
        set[i] = h_ok && s[i] && !h[i] && m_pend[i] && !clr[i];
      end else begin
        nxt[i] = clr[i] ? 1'b0 : (s[i] || m_pend[i]);
      end
    end
    m_err  = ack && !m_pend[ack_idx];
    m_ovr  = set | (m_ovr & ~ovr_clr);
    m_pend = nxt;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_ack(input logic [2:0] idx);
    ack = 1'b1;
    ack_idx = idx;
    cycle();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    m_pend = '0;
    m_ovr  = '0;
    m_err  = 1'b0;
    smp.delete();
    check("rst_pending", {24'd0, pending}, 32'h0);
    check("rst_overrun", {24'd0, overrun}, 32'h0);
    check("rst_req_out", {24'd0, req_out}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    irq_in = '0; mask = '0; ovr_clr = '0; ack = 1'b0; ack_idx = '0;
    cycles(2);
    rst = 1'b0;
    cycles(3);

    // reset with every line high: only the level channel may pend after release
    irq_in = 8'hFF;
    cycles(4);
    do_reset();
    cycles(6);
    check("rst_release_pend", {24'd0, pending}, 32'h01);
    irq_in = 8'h00;
    cycles(3);
    do_ack(3'd0);
    cycles(2);
    check("idle_pend", {24'd0, pending}, 32'h0);

    // latency: rise on channel 5 before edge k, pending at edge k+2
    irq_in[5] = 1'b1;
    cycles(2);
    check("lat_early", {24'd0, pending}, 32'h0);
    cycle();
    check("lat_pend", {24'd0, pending}, 32'h20);
    check("lat_irq", {31'd0, irq}, 32'h1);
    do_ack(3'd5);
    check("lat_ack_pend", {24'd0, pending}, 32'h0);
    check("lat_ack_irq", {31'd0, irq}, 32'h0);

    // mask gating
    irq_in = 8'hB0;
    cycles(3);
    check("mask_pend", {24'd0, pending}, 32'h90);
    mask = 8'h80;
    #1;
    check("mask_req1", {24'd0, req_out}, 32'h10);
    check("mask_irq1", {31'd0, irq}, 32'h1);
    mask = 8'h90;
    #1;
    check("mask_req2", {24'd0, req_out}, 32'h0);
    check("mask_irq2", {31'd0, irq}, 32'h0);
    check("mask_pend2", {24'd0, pending}, 32'h90);
    do_ack(3'd7);
    do_ack(3'd4);
    mask = 8'h00;
    irq_in = 8'h00;
    cycles(3);

    // channel 2: overrun, edge coinciding with ack, write-one-to-clear
    irq_in[2] = 1'b1; cycle();
    irq_in[2] = 1'b0; cycles(2);
    irq_in[2] = 1'b1; cycles(3);
    check("ovr_set", {24'd0, overrun}, 32'h04);
    irq_in[2] = 1'b0; cycle();
    irq_in[2] = 1'b1; cycles(2);
    do_ack(3'd2);
    check("ovr_ack_pend", {31'd0, pending[2]}, 32'h1);
    check("ovr_ack_keep", {24'd0, overrun}, 32'h04);
    ovr_clr = 8'h04; cycle();
    ovr_clr = 8'h00;
    check("ovr_clr", {24'd0, overrun}, 32'h0);
    irq_in = 8'h00;
    do_ack(3'd2);
    cycles(3);

    // level channel 0
    irq_in[0] = 1'b1;
    cycles(3);
    check("lvl_pend", {31'd0, pending[0]}, 32'h1);
    do_ack(3'd0);
    check("lvl_drop", {31'd0, pending[0]}, 32'h0);
    cycle();
    check("lvl_return", {31'd0, pending[0]}, 32'h1);
    irq_in[0] = 1'b0;
    cycles(3);
    do_ack(3'd0);
    cycles(3);
    check("lvl_off", {31'd0, pending[0]}, 32'h0);
    check("lvl_no_ovr", {31'd0, overrun[0]}, 32'h0);

    // ack to a non-pending channel
    do_ack(3'd3);
    check("err_pulse", {31'd0, ack_err}, 32'h1);
    check("err_pend", {24'd0, pending}, 32'h0);
    cycle();
    check("err_once", {31'd0, ack_err}, 32'h0);

    // randomized traffic with one mid-run reset
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(3) == 0) irq_in[b] = ~irq_in[b];
      mask    = 8'($urandom);
      ack     = ($urandom_range(2) == 0);
      ack_idx = 3'($urandom);
      ovr_clr = ($urandom_range(5) == 0) ? 8'($urandom) : 8'h00;
      if (n == 300) do_reset();
      cycle();
    end
    ack = 1'b0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_request_capture.md
Name: irq_request_capture

Overview:
- Upstream front-end for the 8-bit priority encoder.
- Synchronises 8 asynchronous interrupt lines and captures each as edge- or level-triggered into a pending register.
- Presents the masked request vector to the encoder input, plus an any-request flag.
- The consumer returns the encoder's 3-bit index with an ack pulse to retire that request.
- The block tracks per-channel overruns.

Parameters:
- SYNC_STAGES, 2: synchroniser depth per channel; legal range 2..3.
- EDGE_SEL, 8'hFF: per-channel trigger mode; bit i = 1 is rising-edge, bit i = 0 is level-high.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  8  raw interrupt lines, asynchronous to clk.
- mask  input  8  bit i = 1 blocks channel i from req_out; pending state is kept.
- ack  input  1  one-cycle pulse; retires the channel selected by ack_idx.
- ack_idx  input  3  channel index, as produced by the encoder.
- ovr_clr  input  8  write-one-to-clear pulses for the overrun flags.
- req_out  output  8  pending & ~mask; drives the encoder's 8-bit input.
- irq  output  1  OR-reduction of req_out; qualifies the encoder output, whose all-zero case is undefined.
- pending  output  8  raw pending register, unmasked.
- overrun  output  8  sticky per-channel overrun flags.
- ack_err  output  1  one-cycle pulse on an ack to a non-pending channel.

Behaviour:
- Reset: rst high clears all synchroniser flops, edge-history flops, pending, overrun and ack_err immediately, without waiting for a clock edge.
  - Consequently req_out = 0 and irq = 0.
  - Reset mid-operation discards all captured requests; no events are generated on release.
- Synchronisation: irq_in[i] passes through SYNC_STAGES flops, giving s[i]. A history flop h[i] holds the previous s[i].
- Capture event cap[i]:
  - Edge mode: s[i] & ~h[i].
  - Level mode: s[i].
- Latency: an irq_in rise sampled at edge k sets pending at edge k+SYNC_STAGES, and req_out/irq follow combinationally. For SYNC_STAGES = 2, pending is set 2 edges after sampling.
  - Pulses shorter than one clk period may be missed; this is not guaranteed.
- Clear event clr[i]: ack & (ack_idx == i) & pending[i].
- Pending update, per bit:
  - next pending = cap | (pending & ~clr).
  - Capture wins over a simultaneous clear. An edge arriving in the ack cycle re-pends the channel.
  - A level channel whose line is still high re-pends on the cycle after the ack.
- Overrun, edge mode only:
  - overrun[i] sets when cap[i] & pending[i] & ~clr[i].
  - It clears on ovr_clr[i] only when no set condition exists in the same cycle; set wins over clear.
  - Level-mode channels never set overrun.
- ack_err: registered pulse, high for exactly one cycle after ack with pending[ack_idx] == 0. Pending is unchanged in that case.
  - Acking a masked-but-pending channel is legal and clears it.
- Mask: purely combinational gating on the output. Mask changes affect req_out and irq in the same cycle, and pending is never altered by mask.
- Single ack per cycle; ack_idx is only sampled when ack is high.
- No internal state machine beyond the per-channel flop state. All eight channels are independent apart from the shared ack decode.

Decomposition:
- Shared package (irq_pkg):
  - N_CH = 8, IDX_W = 3.
  - Trigger-mode encodings TRIG_LEVEL = 0 and TRIG_EDGE = 1.
  - Default EDGE_SEL constant.
  - The encoder also uses N_CH and IDX_W.
- Sub-module irq_sync_edge: one channel's synchroniser chain, history flop and cap generation, parameterised by SYNC_STAGES and mode.
  - Instantiated 8 times by a generate loop.
  - Pending, overrun and ack decode stay in the top level.

Test Plan:
- Reset: drive irq_in = 8'hFF, assert rst asynchronously between clock edges -> pending, overrun, req_out immediately 0 and irq = 0. Deassert rst with lines steady high (all edge mode) -> no capture.
- Latency and edge capture: SYNC_STAGES = 2, rise irq_in[5] before edge k -> pending = 8'h20 at edge k+2, irq = 1. Ack with ack_idx = 5 -> pending = 0 next edge, irq = 0.
- Mask and encode: pending = 8'h90, mask = 8'h80 -> req_out = 8'h10, irq = 1. Mask = 8'h90 -> req_out = 0, irq = 0, pending still 8'h90.
- Simultaneous events on edge channel 2:
  - Pending set, second edge arrives with no ack -> overrun = 8'h04.
  - New edge coincides with ack of channel 2 -> pending[2] stays 1, overrun unchanged.
  - ovr_clr = 8'h04 -> overrun = 0.
- Level mode: EDGE_SEL = 8'hFE, hold irq_in[0] high, ack with ack_idx = 0 -> pending[0] drops for one cycle, then returns. Release the line and ack -> pending[0] = 0 and stays 0.
- Error path: pending = 0, ack with ack_idx = 3 -> ack_err high for exactly one cycle, pending unchanged.
